// File: rtl/hw_int_ctrl.sv
// hw_int_ctrl - hardware interrupt controller feeding the CP0 HWInt[5:0] input.
//
// Each source is captured either edge-triggered (held as pending until cleared
// by a PEND write-one-to-clear or a CP0 acknowledge) or level-triggered (PEND
// follows the source). Pending bits are masked and priority-encoded, with
// index 0 being the highest priority.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-low reset
//   src      in   6   raw interrupt sources, synchronous to clk
//   addr     in   4   bridge byte offset ([1:0] ignored)
//   we       in   1   bridge write strobe
//   wdata    in   32  bridge write data
//   rdata    out  32  bridge read data, combinational from addr
//   int_ack  in   1   CP0 acknowledge pulse
//   ack_id   in   3   source id being acknowledged
//   hwint    out  6   pend & mask
//   irq      out  1   |hwint
//   irq_id   out  3   lowest set index of hwint, 7 when none
//
// Register map
//   0x0 MASK   RW  [5:0]
//   0x4 MODE   RW  [5:0]  1 = edge, 0 = level
//   0x8 PEND   R/W1C [5:0] (clear only affects edge-mode bits)
//   0xC STATUS RO  {irq at [8], irq_id at [2:0]}
module hw_int_ctrl #(
  parameter int          NSRC     = 6,
  parameter logic [5:0]  MASK_RST = 6'h3f,
  parameter logic [5:0]  MODE_RST = 6'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  src,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        int_ack,
  input  logic [2:0]  ack_id,
  output logic [5:0]  hwint,
  output logic        irq,
  output logic [2:0]  irq_id
);

  // Bits at or above NSRC do not exist: they never store, never assert hwint.
  localparam logic [5:0] VALID = 6'((7'd1 << NSRC) - 7'd1);

  logic [5:0] mask_q;
  logic [5:0] mode_q;
  logic [5:0] pend_q;
  logic [5:0] src_q;

  logic       sel_mask;
  logic       sel_mode;
  logic       sel_pend;
  logic       sel_stat;
  logic [5:0] rise;
  logic [5:0] clr;
  logic [5:0] pend_d;

  logic       unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:6]};

  assign sel_mask = (addr[3:2] == 2'd0);
  assign sel_mode = (addr[3:2] == 2'd1);
  assign sel_pend = (addr[3:2] == 2'd2);
  assign sel_stat = (addr[3:2] == 2'd3);

  assign rise = src & ~src_q;

  always_comb begin
    clr    = '0;
    pend_d = '0;
    for (int i = 0; i < 6; i++) begin
      // ack_id values at or above NSRC match no existing source
      clr[i] = (we & sel_pend & wdata[i]) |
               (int_ack & (ack_id == 3'(i)) & (i < NSRC));
      // A new edge wins over a clear landing in the same cycle
      if (mode_q[i])
        pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
      else
        pend_d[i] = src[i];
    end
    pend_d = pend_d & VALID;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= MASK_RST & VALID;
      mode_q <= MODE_RST & VALID;
      pend_q <= '0;
      src_q  <= '0;
    end else begin
      src_q  <= src;
      pend_q <= pend_d;
      if (we && sel_mask) mask_q <= wdata[5:0] & VALID;
      if (we && sel_mode) mode_q <= wdata[5:0] & VALID;
    end
  end

  assign hwint = pend_q & mask_q;
  assign irq   = |hwint;

  always_comb begin
    irq_id = 3'd7;
    for (int i = 5; i >= 0; i--) begin
      if (hwint[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_mask) rdata = {26'd0, mask_q};
    if (sel_mode) rdata = {26'd0, mode_q};
    if (sel_pend) rdata = {26'd0, pend_q};
    if (sel_stat) rdata = {23'd0, irq, 5'd0, irq_id};
  end

endmodule

// File: tb/tb_hw_int_ctrl.sv
module tb_hw_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [2:0]  ack_id;
  logic [5:0]  hwint;
  logic        irq;
  logic [2:0]  irq_id;

  int n_vec = 0;
  int n_err = 0;

  hw_int_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_ack (int_ack),
    .ack_id  (ack_id),
    .hwint   (hwint),
    .irq     (irq),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  // Reference model: one entry per source, updated from the written rules.
  bit m_mask [6];
  bit m_mode [6];
  bit m_pend [6];
  bit m_prev [6];

  task automatic m_reset();
    for (int i = 0; i < 6; i++) begin
      m_mask[i] = 1'b1;
      m_mode[i] = (i == 2);
      m_pend[i] = 1'b0;
      m_prev[i] = 1'b0;
    end
  endtask

  function automatic logic [5:0] m_hwint();
    logic [5:0] h = '0;
    for (int i = 0; i < 6; i++) h[i] = m_pend[i] && m_mask[i];
    return h;
  endfunction

  function automatic logic [2:0] m_id();
    for (int i = 0; i < 6; i++) if (m_pend[i] && m_mask[i]) return 3'(i);
    return 3'd7;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    int v = 0;
    case (a / 4)
      0: for (int i = 0; i < 6; i++) v += m_mask[i] ? (1 << i) : 0;
      1: for (int i = 0; i < 6; i++) v += m_mode[i] ? (1 << i) : 0;
      2: for (int i = 0; i < 6; i++) v += m_pend[i] ? (1 << i) : 0;
      default: v = ((m_hwint() != 0) ? 256 : 0) + int'(m_id());
    endcase
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle, advance the model, return 1 ns after the edge.
  task automatic cyc(input logic [5:0] s, input logic w, input logic [3:0] a,
                     input logic [31:0] wd, input logic ak, input logic [2:0] aid);
    bit np [6];
    src = s; we = w; addr = a; wdata = wd; int_ack = ak; ack_id = aid;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        bit rose = s[i] && !m_prev[i];
        bit gone = (w && a[3:2] == 2'd2 && wd[i]) || (ak && int'(aid) == i);
        np[i] = rose ? 1'b1 : (gone ? 1'b0 : m_pend[i]);
      end else begin
        np[i] = s[i];
      end
    end
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = s[i];
      if (w && a[3:2] == 2'd0) m_mask[i] = wd[i];
      if (w && a[3:2] == 2'd1) m_mode[i] = wd[i];
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " hwint"}, 32'(hwint), 32'(m_hwint()));
    chk({tag, " irq"}, 32'(irq), 32'(m_hwint() != 0));
    chk({tag, " irq_id"}, 32'(irq_id), 32'(m_id()));
    chk({tag, " rdata"}, rdata, m_rdata(addr));
  endtask

  typedef struct {
    logic [5:0]  s;
    logic        w;
    logic [3:0]  a;
    logic [31:0] wd;
    logic        ak;
    logic [2:0]  aid;
    logic [5:0]  hw;
    logic        ir;
    logic [2:0]  id;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic [5:0] s, input logic w, input logic [3:0] a,
                      input logic [31:0] wd, input logic ak, input logic [2:0] aid,
                      input logic [5:0] hw, input logic ir, input logic [2:0] id,
                      input logic [31:0] rd);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.wd = wd; v.ak = ak; v.aid = aid;
    v.hw = hw; v.ir = ir; v.id = id; v.rd = rd;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] rs;
    string tag;

    reset = 1'b0; src = '0; addr = '0; we = 1'b0; wdata = '0;
    int_ack = 1'b0; ack_id = '0;
    m_reset();

    //      src    we  addr  wdata         ack  id    hwint  irq id    rdata
    addv(6'h00, 0, 4'h0, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h03f);
    addv(6'h00, 0, 4'h4, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h00, 0, 4'hC, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h007);
    addv(6'h04, 0, 4'hC, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h102);
    addv(6'h00, 0, 4'h8, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h004);
    for (int k = 0; k < 5; k++)
      addv(6'h01, 0, 4'hC, 32'h0,      0, 3'd0, 6'h05, 1, 3'd0, 32'h100);
    addv(6'h00, 0, 4'hC, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h102);
    addv(6'h00, 0, 4'h8, 32'h0,        1, 3'd2, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h00, 1, 4'h0, 32'h3b,       0, 3'd0, 6'h00, 0, 3'd7, 32'h03b);
    addv(6'h04, 0, 4'h8, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h004);
    addv(6'h00, 1, 4'h0, 32'h3f,       0, 3'd0, 6'h04, 1, 3'd2, 32'h03f);
    addv(6'h04, 0, 4'h8, 32'h0,        1, 3'd2, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h04, 1, 4'h8, 32'h04,       0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h04, 0, 4'h8, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h00, 0, 4'h8, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h01, 1, 4'h8, 32'h01,       0, 3'd0, 6'h01, 1, 3'd0, 32'h001);
    addv(6'h00, 0, 4'h4, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h004);
    addv(6'h00, 1, 4'h4, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h04, 0, 4'h8, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h00, 1, 4'h4, 32'h04,       0, 3'd0, 6'h00, 0, 3'd7, 32'h004);
    addv(6'h00, 1, 4'hC, 32'hffffffff, 0, 3'd0, 6'h00, 0, 3'd7, 32'h007);
    addv(6'h00, 1, 4'h0, 32'hffffffc0, 0, 3'd0, 6'h00, 0, 3'd7, 32'h000);
    addv(6'h00, 1, 4'h0, 32'h3f,       0, 3'd0, 6'h00, 0, 3'd7, 32'h03f);
    addv(6'h04, 0, 4'h8, 32'h0,        0, 3'd0, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        1, 3'd6, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        1, 3'd7, 6'h04, 1, 3'd2, 32'h004);
    addv(6'h00, 0, 4'h8, 32'h0,        1, 3'd2, 6'h00, 0, 3'd7, 32'h000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].s, tbl[k].w, tbl[k].a, tbl[k].wd, tbl[k].ak, tbl[k].aid);
      tag = $sformatf("vec%0d", k);
      chk({tag, " hwint"}, 32'(hwint), 32'(tbl[k].hw));
      chk({tag, " irq"}, 32'(irq), 32'(tbl[k].ir));
      chk({tag, " irq_id"}, 32'(irq_id), 32'(tbl[k].id));
      chk({tag, " rdata"}, rdata, tbl[k].rd);
    end

    // Reset asserted mid-operation with PEND=0x05, MASK=0x00
    cyc(6'h00, 1, 4'h0, 32'h0, 0, 3'd0);
    cyc(6'h05, 0, 4'h8, 32'h0, 0, 3'd0);
    chk("pre-reset pend", rdata, 32'h005);
    chk("pre-reset hwint", 32'(hwint), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("async reset pend", rdata, 32'h000);
    chk("async reset irq", 32'(irq), 32'h0);
    addr = 4'h0;
    #1;
    chk("async reset mask", rdata, 32'h03f);
    src = 6'h00;
    m_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(6'h00, 0, 4'hC, 32'h0, 0, 3'd0);
    chk("post-reset status", rdata, 32'h007);
    chk("post-reset irq", 32'(irq), 32'h0);
    cyc(6'h04, 0, 4'hC, 32'h0, 0, 3'd0);
    chk("post-reset event", rdata, 32'h102);

    // Randomized traffic against the model
    rs = 6'h00;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ra;
      rs = rs ^ 6'($urandom & $urandom);
      ra = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      cyc(rs, ($urandom_range(0, 3) == 0), ra, $urandom,
          ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
